sub_abs_sub_arb: RTL

SUB_ABS_SUB_ARB -- requirements
Module: sub_abs_sub_arb

---
 rtl/sub_abs_sub_pkg.sv | 8 +
 rtl/rr_arb.sv | 20 ++
 rtl/sub_abs_sub_arb.sv | 103 ++++++++++
 3 files changed

// File: rtl/sub_abs_sub_pkg.sv
// sub_abs_sub_pkg: shared FSM encoding and statistics width for the sub_abs_sub arbiter.
package sub_abs_sub_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int OP_CNT_W = 16;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: one-hot round-robin grant starting at (last_grant+1) mod NREQ.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] idx;
    // Scan farthest-first so the requester closest after last_grant overwrites the rest.
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (req[idx]) grant = NREQ'(1) << idx;
        end
    end
endmodule

// File: rtl/sub_abs_sub_arb.sv
// sub_abs_sub_arb: round-robin front end sharing one sub_abs_sub datapath among NREQ requesters.
// Optional SUB_ABS_SUB_ARB_STATS_EN adds a saturating op_cnt of completed responses.
module sub_abs_sub_arb
    import sub_abs_sub_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int W      = 8,
    parameter int DP_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_op1,
    input  logic [NREQ*W-1:0]       req_op2,
    output logic [NREQ-1:0]         req_ready,
    output logic [W-1:0]            dp_op1,
    output logic [W-1:0]            dp_op2,
    output logic                    dp_en,
    input  logic [W-1:0]            dp_res,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_res,
    input  logic                    rsp_ready
`ifdef SUB_ABS_SUB_ARB_STATS_EN
    ,
    output logic [OP_CNT_W-1:0]     op_cnt
`endif
);
    localparam int IW = $clog2(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   last_grant, gid;
    logic [3:0]      cnt;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    gop1, gop2;
    logic            go, last;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        gid = '0;
        gop1 = '0;
        gop2 = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) begin
                gid = IW'(i);
                gop1 = req_op1[i*W +: W];
                gop2 = req_op2[i*W +: W];
            end
    end

    assign go        = state == IDLE && |req_valid;
    assign last      = cnt == 4'(DP_LAT - 1);
    assign req_ready = go ? grant : '0;
    assign rsp_valid = state == RESP;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req_valid) state_nx = WAIT;
            WAIT:    if (last) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cnt restarts at 0 on the dp_en cycle, the first WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            cnt        <= '0;
            dp_en      <= 1'b0;
            dp_op1     <= '0;
            dp_op2     <= '0;
            rsp_id     <= '0;
            rsp_res    <= '0;
        end else begin
            state <= state_nx;
            dp_en <= go;
            cnt   <= state == WAIT ? cnt + 4'd1 : '0;
            if (go) begin
                last_grant <= gid;
                rsp_id     <= gid;
                dp_op1     <= gop1;
                dp_op2     <= gop2;
            end
            if (state == WAIT && last) rsp_res <= dp_res;
        end
    end

`ifdef SUB_ABS_SUB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) op_cnt <= '0;
        else if (rsp_valid && rsp_ready && op_cnt != '1) op_cnt <= op_cnt + 1'b1;
    end
`endif

endmodule
